// File: rtl/alu_seq_pkg.sv
// Shared sequencer/ALU definitions: state encoding, op select width and op codes.
package alu_seq_pkg;

  localparam int OP_W = 2;

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_OP = 3'd2,
    ISSUE   = 3'd3,
    WAIT    = 3'd4,
    SEND    = 3'd5
  } seq_state_e;

  typedef enum logic [OP_W-1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    CMP = 2'd3
  } alu_op_e;

  // Byte-index counter width; a single-byte word still needs one bit.
  function automatic int cnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/alu_byte_sequencer_byte_shift_reg.sv
// WIDTH-bit register written one byte at a time at a selectable byte index.
module byte_shift_reg #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       din,
  output logic [WIDTH-1:0] q
);
  import alu_seq_pkg::*;

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (we) begin
      for (int i = 0; i < NB; i++) begin
        if (idx == IDX_W'(i)) q_d[i*8 +: 8] = din;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/alu_byte_sequencer.sv
// Byte-serial operand loader, ALU issue/wait handshake and result byte streamer.
module alu_byte_sequencer #(
  parameter int WIDTH = 32,
  parameter int OP_W  = alu_seq_pkg::OP_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             abort,
  input  logic [7:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_op,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_done,
  output logic [7:0]       dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy
);
  import alu_seq_pkg::*;

  localparam int NBYTES = WIDTH / 8;
  localparam int CNT_W  = cnt_width(NBYTES);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NBYTES - 1);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_seen_q, done_seen_d;
  logic [7:0]       dout_q, dout_d;
  logic             we_a, we_b, clr_ops;

  function automatic logic [7:0] byte_at(input logic [WIDTH-1:0] w,
                                         input logic [CNT_W-1:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx == CNT_W'(i)) b = w[i*8 +: 8];
    end
    return b;
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    result_d    = result_q;
    done_seen_d = done_seen_q;
    we_a        = 1'b0;
    we_b        = 1'b0;
    clr_ops     = 1'b0;

    if (abort) begin
      state_d     = LOAD_A;
      cnt_d       = '0;
      op_d        = '0;
      done_seen_d = 1'b0;
      clr_ops     = 1'b1;
    end else begin
      // The done pulse is captured even while stalled so it is never lost.
      if (state_q == WAIT && alu_done && !done_seen_q) begin
        result_d    = alu_result;
        done_seen_d = 1'b1;
      end
      if (ena) begin
        unique case (state_q)
          LOAD_A: if (din_valid) begin
            we_a = 1'b1;
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = LOAD_B;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          LOAD_B: if (din_valid) begin
            we_b = 1'b1;
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = LOAD_OP;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          LOAD_OP: if (din_valid) begin
            op_d    = din[OP_W-1:0];
            state_d = ISSUE;
          end
          ISSUE: state_d = WAIT;
          WAIT: if (done_seen_q || alu_done) begin
            state_d     = SEND;
            done_seen_d = 1'b0;
          end
          SEND: if (dout_ready) begin
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = LOAD_A;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
          default: begin
            state_d = LOAD_A;
            cnt_d   = '0;
          end
        endcase
      end
    end

    // Output byte is pre-selected from next-cycle values so dout is a flop.
    dout_d = byte_at(result_d, cnt_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD_A;
      cnt_q       <= '0;
      op_q        <= '0;
      result_q    <= '0;
      done_seen_q <= 1'b0;
      dout_q      <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      result_q    <= result_d;
      done_seen_q <= done_seen_d;
      dout_q      <= dout_d;
    end
  end

  byte_shift_reg #(.WIDTH(WIDTH), .IDX_W(CNT_W)) u_opa (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_ops),
    .we    (we_a),
    .idx   (cnt_q),
    .din   (din),
    .q     (alu_a)
  );

  byte_shift_reg #(.WIDTH(WIDTH), .IDX_W(CNT_W)) u_opb (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr_ops),
    .we    (we_b),
    .idx   (cnt_q),
    .din   (din),
    .q     (alu_b)
  );

  assign din_ready  = ena && (state_q inside {LOAD_A, LOAD_B, LOAD_OP});
  assign alu_start  = ena && !abort && (state_q == ISSUE);
  assign dout_valid = ena && !abort && (state_q == SEND);
  assign dout       = dout_q;
  assign alu_op     = op_q;
  assign busy       = (state_q != LOAD_A) || (cnt_q != '0);

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Self-checking bench: directed vector table, random transactions vs. a transaction-level model.
`timescale 1ns/1ps
module tb_alu_byte_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        abort = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [31:0] alu_a, alu_b;
  logic [1:0]  alu_op;
  logic        alu_start;
  logic [31:0] alu_result = 32'h0;
  logic        alu_done = 1'b0;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        busy;

  int passed = 0;
  int total  = 0;

  alu_byte_sequencer #(.WIDTH(32), .OP_W(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .abort      (abort),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_result (alu_result),
    .alu_done   (alu_done),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  opbyte;
    logic [1:0]  exp_op;
    logic [31:0] res;
    int          lat;
    int          mode;     // 0: ready always, 1: ready 1,0,0 repeating, 2: random
    bit          ena_gap;
    logic [31:0] exp_seq;  // expected dout bytes, first byte in [31:24]
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends A, B and op bytes; returns in the cycle alu_start should be high.
  task automatic feed(input logic [31:0] a, input logic [31:0] b, input logic [7:0] opbyte,
                      input logic [1:0] exp_op, input bit ena_gap);
    logic [7:0] seq [9];
    for (int i = 0; i < 4; i++) begin
      seq[i]   = a[8*i +: 8];
      seq[4+i] = b[8*i +: 8];
    end
    seq[8] = opbyte;
    for (int i = 0; i < 9; i++) begin
      din       = seq[i];
      din_valid = 1'b1;
      if (ena_gap && i == 6) begin
        ena = 1'b0;
        for (int k = 0; k < 5; k++) begin
          #1;
          chk("din_ready_stalled", 32'(din_ready), 32'd0);
          chk("busy_stalled", 32'(busy), 32'd1);
          tick();
        end
        ena = 1'b1;
      end
      #1;
      chk("din_ready_load", 32'(din_ready), 32'd1);
      tick();
      if (i == 0) chk("busy_after_first", 32'(busy), 32'd1);
    end
    din_valid = 1'b0;
    #1;
    chk("alu_a", alu_a, a);
    chk("alu_b", alu_b, b);
    chk("alu_op", 32'(alu_op), 32'(exp_op));
    chk("alu_start_issue", 32'(alu_start), 32'd1);
    chk("din_ready_issue", 32'(din_ready), 32'd0);
  endtask

  // Plays the ALU: done pulse lat cycles after start; returns in the first SEND cycle.
  task automatic alu_reply(input logic [31:0] res, input int lat, input bit ena_gap);
    for (int k = 1; k <= lat; k++) begin
      tick();
      chk("alu_start_single", 32'(alu_start), 32'd0);
    end
    if (ena_gap) begin
      ena = 1'b0;
      tick();
      alu_done   = 1'b1;
      alu_result = res;
      #1;
      chk("dout_valid_ena0", 32'(dout_valid), 32'd0);
      tick();
      alu_done   = 1'b0;
      alu_result = 32'hA5A5_A5A5;
      for (int k = 0; k < 3; k++) begin
        chk("dout_valid_ena0_hold", 32'(dout_valid), 32'd0);
        chk("busy_wait_ena0", 32'(busy), 32'd1);
        tick();
      end
      ena = 1'b1;
      tick();
    end else begin
      alu_done   = 1'b1;
      alu_result = res;
      tick();
      alu_done   = 1'b0;
      alu_result = 32'h5A5A_5A5A;
    end
  endtask

  task automatic collect(input logic [31:0] exp_seq, input int mode, input int n);
    int got = 0;
    int cyc = 0;
    logic r;
    while (got < n && cyc < 200) begin
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      dout_ready = r;
      #1;
      chk("dout_valid_send", 32'(dout_valid), 32'd1);
      chk("dout_byte", 32'(dout), 32'(exp_seq[31-8*got -: 8]));
      if (r) got++;
      tick();
      cyc++;
    end
    dout_ready = 1'b0;
    chk("bytes_taken", got, n);
  endtask

  task automatic run_txn(input vec_t v);
    feed(v.a, v.b, v.opbyte, v.exp_op, v.ena_gap);
    alu_reply(v.res, v.lat, v.ena_gap);
    collect(v.exp_seq, v.mode, 4);
    #1;
    chk("busy_idle", 32'(busy), 32'd0);
    chk("dout_valid_idle", 32'(dout_valid), 32'd0);
    chk("din_ready_idle", 32'(din_ready), 32'd1);
    chk("alu_a_held", alu_a, v.a);
    chk("alu_b_held", alu_b, v.b);
    chk("alu_op_held", 32'(alu_op), 32'(v.exp_op));
  endtask

  // Stand-in ALU behaviour used to pick results for random transactions.
  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] op);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a * b;
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  vec_t vecs [4];
  vec_t rv;

  initial begin
    vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 8'h01, 2'd1, 32'hBF80_0000, 3, 0, 1'b0, 32'h0000_80BF};
    vecs[1] = '{32'h3F80_0000, 32'h4000_0000, 8'h01, 2'd1, 32'hBF80_0000, 3, 1, 1'b0, 32'h0000_80BF};
    vecs[2] = '{32'h1122_3344, 32'h5566_7788, 8'hFE, 2'd2, 32'h1234_5678, 3, 0, 1'b1, 32'h7856_3412};
    vecs[3] = '{32'hFFFF_FFFF, 32'h0000_0001, 8'h03, 2'd3, 32'h8000_0001, 1, 1, 1'b0, 32'h0100_0080};

    #12;
    chk("rst_alu_a", alu_a, 32'h0);
    chk("rst_alu_b", alu_b, 32'h0);
    chk("rst_alu_op", 32'(alu_op), 32'h0);
    chk("rst_alu_start", 32'(alu_start), 32'h0);
    chk("rst_dout", 32'(dout), 32'h0);
    chk("rst_dout_valid", 32'(dout_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("din_ready_after_reset", 32'(din_ready), 32'd1);

    for (int i = 0; i < 4; i++) run_txn(vecs[i]);

    // Abort while waiting on the ALU, then a stale done that must be ignored.
    feed(32'hCAFE_BABE, 32'h0BAD_F00D, 8'h00, 2'd0, 1'b0);
    tick();
    abort = 1'b1;
    #1;
    chk("abort_start", 32'(alu_start), 32'd0);
    chk("abort_dout_valid", 32'(dout_valid), 32'd0);
    tick();
    abort = 1'b0;
    #1;
    chk("abort_alu_a", alu_a, 32'h0);
    chk("abort_alu_b", alu_b, 32'h0);
    chk("abort_alu_op", 32'(alu_op), 32'h0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_din_ready", 32'(din_ready), 32'd1);
    alu_done   = 1'b1;
    alu_result = 32'hDEAD_BEEF;
    tick();
    alu_done = 1'b0;
    for (int k = 0; k < 2; k++) begin
      chk("stale_dout_valid", 32'(dout_valid), 32'd0);
      chk("stale_busy", 32'(busy), 32'd0);
      tick();
    end
    run_txn(vecs[3]);

    // Asynchronous reset in the middle of sending the result.
    feed(32'h0102_0304, 32'h0506_0708, 8'h02, 2'd2, 1'b0);
    alu_reply(32'hCAFE_F00D, 2, 1'b0);
    collect(32'h0DF0_FECA, 0, 2);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_alu_a", alu_a, 32'h0);
    chk("arst_alu_b", alu_b, 32'h0);
    chk("arst_alu_op", 32'(alu_op), 32'h0);
    chk("arst_alu_start", 32'(alu_start), 32'h0);
    chk("arst_dout", 32'(dout), 32'h0);
    chk("arst_dout_valid", 32'(dout_valid), 32'h0);
    chk("arst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("arst_din_ready", 32'(din_ready), 32'd1);
    chk("arst_busy_after", 32'(busy), 32'd0);
    run_txn(vecs[0]);

    for (int t = 0; t < 16; t++) begin
      rv.a       = $urandom;
      rv.b       = $urandom;
      rv.opbyte  = 8'($urandom);
      rv.exp_op  = rv.opbyte[1:0];
      rv.res     = alu_model(rv.a, rv.b, rv.exp_op);
      rv.lat     = $urandom_range(1, 5);
      rv.mode    = 2;
      rv.ena_gap = 1'($urandom_range(0, 1));
      rv.exp_seq = {rv.res[7:0], rv.res[15:8], rv.res[23:16], rv.res[31:24]};
      run_txn(rv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/alu_byte_sequencer.md
Name: alu_byte_sequencer

Overview:
- Byte-serial front/back end for the floating-point ALU datapath; the TinyTapeout top wrapper feeds it from its 8-bit pins.
- Assembles two WIDTH-bit operands and an op byte from an 8-bit input stream, then issues one ALU operation with a start/done handshake.
- Captures the result and streams it back out one byte at a time.
- Sits directly upstream of the ALU (drives operands and op select) and directly downstream of it (consumes the result).

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of 8.
- OP_W, 2, width of the ALU operation select.
- NBYTES, WIDTH/8, bytes per operand; derived, not overridable.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  design enable; 0 stalls the sequencer.
- abort  input  1  synchronous clear of the current transaction.
- din  input  8  serial input byte.
- din_valid  input  1  din holds a byte.
- din_ready  output  1  sequencer accepts din this cycle.
- alu_a  output  WIDTH  operand A to the ALU.
- alu_b  output  WIDTH  operand B to the ALU.
- alu_op  output  OP_W  operation select to the ALU.
- alu_start  output  1  one-cycle issue pulse.
- alu_result  input  WIDTH  ALU result.
- alu_done  input  1  alu_result is valid this cycle.
- dout  output  8  serial result byte.
- dout_valid  output  1  dout holds a byte.
- dout_ready  input  1  consumer takes dout this cycle.
- busy  output  1  high whenever the state is not LOAD_A, or byte count is nonzero.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. During reset:
  - state = LOAD_A, byte counter = 0.
  - alu_a, alu_b, alu_op, result register, dout = 0.
  - alu_start, dout_valid, busy = 0.
- Byte order: little-endian, first byte lands in bits [7:0]. Op byte uses din[OP_W-1:0]; upper bits are ignored.
- Input handshake: a byte transfers when din_valid && din_ready. din_ready = ena && state in {LOAD_A, LOAD_B, LOAD_OP}; it is combinational from state and ena only.
- States:
  - LOAD_A: accept NBYTES bytes into alu_a; after the last byte, go to LOAD_B.
  - LOAD_B: same for alu_b; then go to LOAD_OP.
  - LOAD_OP: one byte into alu_op; then go to ISSUE.
  - ISSUE: assert alu_start for exactly one cycle, registered, on the cycle after the op byte is accepted; next cycle go to WAIT.
  - WAIT: on alu_done, register alu_result and go to SEND. alu_done is sampled even when ena = 0, so a done pulse is never lost.
  - SEND: dout = result byte[count]; dout_valid = 1. On dout_ready, advance the count. After byte NBYTES-1 is taken, go to LOAD_A with count = 0.
- Operand stability: alu_a, alu_b and alu_op are held stable from ISSUE until the next LOAD_A byte is written. They are never cleared between transactions, except by reset or abort.
- Latency: alu_start rises 1 cycle after op-byte acceptance. The first dout_valid rises 1 cycle after alu_done. alu_done in the same cycle as alu_start is illegal; the ALU takes at least 1 cycle.
- dout is registered and stable while dout_valid = 1 && dout_ready = 0.
- ena = 0:
  - State, counter and operands hold.
  - din_ready = 0 and dout_valid = 0; ISSUE does not pulse alu_start until ena returns.
  - WAIT still captures alu_done, but the transition to SEND completes only when ena = 1. The result is held in the register meanwhile.
- abort = 1 (priority over all other events in that cycle):
  - Next state = LOAD_A, count = 0, alu_start = 0, dout_valid = 0, alu_a/alu_b/alu_op = 0.
  - If aborted in WAIT, a later alu_done is ignored while in LOAD states.
- Simultaneous din_valid in SEND or WAIT: not accepted (din_ready = 0); the upstream must hold the byte.
- Counter width = clog2(NBYTES), minimum 1. It wraps to 0 at each phase boundary and never overflows.
- Reset mid-operation: immediate return to the reset values above; no partial output is emitted.

Decomposition:
- Shared package alu_seq_pkg holds:
  - State enum: LOAD_A, LOAD_B, LOAD_OP, ISSUE, WAIT, SEND (3-bit encoding).
  - OP_W constant and the op codes ADD = 0, SUB = 1, MUL = 2, CMP = 3, shared with the ALU.
- One natural sub-module: byte_shift_reg (WIDTH-bit, load-byte-at-index / read-byte-at-index). Instantiate it twice for the operand assembly; result serialization uses a mux on the result register.

Test Plan:
- Load A = 0x3F800000 (bytes 00,00,80,3F), B = 0x40000000, op = 0x01 with din_valid held high -> din_ready high for 9 cycles; alu_a = 0x3F800000, alu_b = 0x40000000, alu_op = 1; alu_start pulses once, 1 cycle after the 9th byte.
- ALU model returns 0xBF800000 with alu_done 3 cycles after start, dout_ready = 1 -> dout sequence 00,00,80,BF on 4 consecutive cycles; busy drops after the 4th byte.
- Same transaction with dout_ready toggling 1,0,0,1,... -> each byte is held unchanged until taken; no byte is dropped or duplicated.
- ena forced 0 for 5 cycles midway through LOAD_B, and again during WAIT with alu_done pulsing while ena = 0 -> loading resumes at the same byte index; result 0x12345678 still emerges as 78,56,34,12 after ena returns.
- abort asserted in WAIT, then a stale alu_done, then a new full transaction -> stale result is never output; the new transaction's operands and output are correct.
- rst_n asserted asynchronously mid-SEND after 2 bytes -> all outputs 0 immediately; after release, din_ready = 1 and state is LOAD_A with count 0.
